// File: rtl/branch_resolver_pkg.sv
// Shared constants for the branch resolver: word/flag values, FSM encodings
// and the default fall-through increment.
package branch_resolver_pkg;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;
   localparam logic        Enable   = 1'b1;
   localparam logic        Disable  = 1'b0;

   localparam logic [0:0]  StIdle     = 1'b0;
   localparam logic [0:0]  StRedirect = 1'b1;

   localparam int unsigned InstBytesDefault = 4;

endpackage

// File: rtl/branch_stat_counter.sv
// Saturating event counter with a single-cycle enable; sticks at all-ones
// until rst clears it.
module branch_stat_counter
   import branch_resolver_pkg::*;
#(
   parameter int unsigned STAT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_en,
   output logic [STAT_WIDTH-1:0] o_count
);

   logic [STAT_WIDTH-1:0] r_count;
   logic                  w_sat;

   assign w_sat   = (r_count == {STAT_WIDTH{Enable}});
   assign o_count = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_en && !w_sat) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: registered BTB update, mispredict flush and a held
// redirect to IF. Statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int unsigned PC_WIDTH   = 32,
   parameter int unsigned INST_BYTES = InstBytesDefault,
   parameter int unsigned STAT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  ex_valid,
   input  logic                  ex_is_branch,
   input  logic [PC_WIDTH-1:0]   ex_pc,
   input  logic                  ex_taken,
   input  logic [PC_WIDTH-1:0]   ex_target,
   input  logic                  ex_pred_taken,
   input  logic [PC_WIDTH-1:0]   ex_pred_addr,
   output logic [PC_WIDTH-1:0]   pc_to_btb,
   output logic                  branch_to_btb,
   output logic                  jump_to_btb,
   output logic [PC_WIDTH-1:0]   jump_addr_to_btb,
   output logic                  flush_o,
   output logic                  redirect_to_if,
   output logic [PC_WIDTH-1:0]   redirect_addr_to_if,
   input  logic                  redirect_ack_from_if,
   output logic [STAT_WIDTH-1:0] stat_branches,
   output logic [STAT_WIDTH-1:0] stat_mispredicts
);

   logic [0:0]          r_state;
   logic                r_branch;
   logic                r_jump;
   logic                r_flush;
   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] r_addr;
   logic [PC_WIDTH-1:0] r_redirect_addr;

   logic                w_resolve;
   logic                w_wrong;
   logic                w_mispredict;
   logic [PC_WIDTH-1:0] w_redirect_pc;

   // Anything in EX while a redirect is pending is wrong-path and never resolves.
   assign w_resolve    = ex_valid & ex_is_branch & rdy & (r_state == StIdle);
   assign w_wrong      = (ex_pred_taken != ex_taken) | (ex_taken & (ex_pred_addr != ex_target));
   assign w_mispredict = w_resolve & w_wrong;
   assign w_redirect_pc = ex_taken ? ex_target : ex_pc + PC_WIDTH'(INST_BYTES);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= StIdle;
         r_branch        <= Disable;
         r_jump          <= Disable;
         r_flush         <= Disable;
         r_pc            <= '0;
         r_addr          <= '0;
         r_redirect_addr <= '0;
      end else if (rdy) begin
         r_branch <= w_resolve;
         r_flush  <= w_mispredict;
         if (w_resolve) begin
            r_pc   <= ex_pc;
            r_jump <= ex_taken;
            r_addr <= ex_target;
         end
         if (w_mispredict) begin
            r_state         <= StRedirect;
            r_redirect_addr <= w_redirect_pc;
         end else if ((r_state == StRedirect) && redirect_ack_from_if) begin
            r_state <= StIdle;
         end
      end
   end

   assign pc_to_btb           = r_pc;
   assign branch_to_btb       = r_branch;
   assign jump_to_btb         = r_jump;
   assign jump_addr_to_btb    = r_addr;
   assign flush_o             = r_flush;
   assign redirect_to_if      = (r_state == StRedirect);
   assign redirect_addr_to_if = r_redirect_addr;

`ifdef BRANCH_STATS_EN
   branch_stat_counter #(
      .STAT_WIDTH (STAT_WIDTH)
   ) u_stat_branches (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_resolve),
      .o_count (stat_branches)
   );

   branch_stat_counter #(
      .STAT_WIDTH (STAT_WIDTH)
   ) u_stat_mispredicts (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_mispredict),
      .o_count (stat_mispredicts)
   );
`else
   assign stat_branches    = '0;
   assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed vector table, rdy/rst corner
// sequences and a randomized run against a behavioural model.
module tb_branch_resolver;

   localparam int unsigned SW = 4;

   typedef struct packed {
      logic        valid;
      logic        is_branch;
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
      logic        pred_taken;
      logic [31:0] pred_addr;
      logic        ack;
      logic        rdy;
   } in_t;

   typedef struct packed {
      logic        branch;
      logic        jump;
      logic        flush;
      logic        redirect;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] raddr;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           rdy, ex_valid, ex_is_branch, ex_taken, ex_pred_taken, ack;
   logic [31:0]    ex_pc, ex_target, ex_pred_addr;
   logic [31:0]    pc_to_btb, jump_addr_to_btb, redirect_addr_to_if;
   logic           branch_to_btb, jump_to_btb, flush_o, redirect_to_if;
   logic [SW-1:0]  stat_branches, stat_mispredicts;

   int checks = 0;
   int errors = 0;

   // Model state
   out_t m_out;
   bit   m_redirect;
   int   m_nb, m_nm;

   always #5 clk = ~clk;

   branch_resolver #(
      .PC_WIDTH   (32),
      .INST_BYTES (4),
      .STAT_WIDTH (SW)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .rdy                  (rdy),
      .ex_valid             (ex_valid),
      .ex_is_branch         (ex_is_branch),
      .ex_pc                (ex_pc),
      .ex_taken             (ex_taken),
      .ex_target            (ex_target),
      .ex_pred_taken        (ex_pred_taken),
      .ex_pred_addr         (ex_pred_addr),
      .pc_to_btb            (pc_to_btb),
      .branch_to_btb        (branch_to_btb),
      .jump_to_btb          (jump_to_btb),
      .jump_addr_to_btb     (jump_addr_to_btb),
      .flush_o              (flush_o),
      .redirect_to_if       (redirect_to_if),
      .redirect_addr_to_if  (redirect_addr_to_if),
      .redirect_ack_from_if (ack),
      .stat_branches        (stat_branches),
      .stat_mispredicts     (stat_mispredicts)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag, input out_t e);
      chk({tag, ".branch"},   64'(branch_to_btb),       64'(e.branch));
      chk({tag, ".jump"},     64'(jump_to_btb),         64'(e.jump));
      chk({tag, ".flush"},    64'(flush_o),             64'(e.flush));
      chk({tag, ".redirect"}, 64'(redirect_to_if),      64'(e.redirect));
      chk({tag, ".pc"},       64'(pc_to_btb),           64'(e.pc));
      chk({tag, ".addr"},     64'(jump_addr_to_btb),    64'(e.addr));
      chk({tag, ".raddr"},    64'(redirect_addr_to_if), 64'(e.raddr));
   endtask

   task automatic check_stats(input string tag, input int nb, input int nm);
`ifdef BRANCH_STATS_EN
      chk({tag, ".stat_br"}, 64'(stat_branches),    64'(nb));
      chk({tag, ".stat_mp"}, 64'(stat_mispredicts), 64'(nm));
`else
      chk({tag, ".stat_br"}, 64'(stat_branches),    64'(nb * 0));
      chk({tag, ".stat_mp"}, 64'(stat_mispredicts), 64'(nm * 0));
`endif
   endtask

   task automatic drive(input in_t x);
      rdy           = x.rdy;
      ex_valid      = x.valid;
      ex_is_branch  = x.is_branch;
      ex_pc         = x.pc;
      ex_taken      = x.taken;
      ex_target     = x.target;
      ex_pred_taken = x.pred_taken;
      ex_pred_addr  = x.pred_addr;
      ack           = x.ack;
   endtask

   // Behavioural view: what the outputs must show after the edge that samples x.
   task automatic model_step(input in_t x);
      bit resolve, wrong;
      int sat;
      sat = (1 << SW) - 1;
      if (!x.rdy) return;
      resolve = x.valid && x.is_branch && !m_redirect;
      wrong   = (x.pred_taken != x.taken) || (x.taken && (x.pred_addr != x.target));
      m_out.branch = resolve;
      m_out.flush  = resolve && wrong;
      if (resolve) begin
         m_out.pc   = x.pc;
         m_out.jump = x.taken;
         m_out.addr = x.target;
         m_nb = (m_nb + 1 > sat) ? sat : m_nb + 1;
      end
      if (resolve && wrong) begin
         m_redirect  = 1'b1;
         m_out.raddr = x.taken ? x.target : x.pc + 32'd4;
         m_nm = (m_nm + 1 > sat) ? sat : m_nm + 1;
      end else if (m_redirect && x.ack) begin
         m_redirect = 1'b0;
      end
      m_out.redirect = m_redirect;
   endtask

   task automatic do_reset();
      in_t idle;
      idle = '0;
      idle.rdy = 1'b1;
      drive(idle);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      m_out = '0;
      m_redirect = 1'b0;
      m_nb = 0;
      m_nm = 0;
   endtask

   function automatic in_t mk(input logic v, input logic b, input logic [31:0] pc,
                              input logic t, input logic [31:0] tgt, input logic pt,
                              input logic [31:0] pa, input logic a);
      in_t x;
      x = '{valid: v, is_branch: b, pc: pc, taken: t, target: tgt, pred_taken: pt,
            pred_addr: pa, ack: a, rdy: 1'b1};
      return x;
   endfunction

   function automatic out_t eo(input logic br, input logic j, input logic f, input logic r,
                               input logic [31:0] pc, input logic [31:0] ad,
                               input logic [31:0] ra);
      out_t o;
      o = '{branch: br, jump: j, flush: f, redirect: r, pc: pc, addr: ad, raddr: ra};
      return o;
   endfunction

   initial begin
      vec_t tbl[14];
      in_t  x;
      out_t e;

      x = '0;
      drive(x);
      #2;
      check_outs("reset", '0);
      check_stats("reset", 0, 0);
      do_reset();

      tbl[0]  = '{mk(1, 1, 32'h100, 1, 32'h180, 1, 32'h180, 0),
                  eo(1, 1, 0, 0, 32'h100, 32'h180, 32'h0)};
      tbl[1]  = '{mk(0, 1, 32'h104, 1, 32'h999, 0, 32'h0, 0),
                  eo(0, 1, 0, 0, 32'h100, 32'h180, 32'h0)};
      tbl[2]  = '{mk(1, 1, 32'h200, 0, 32'h250, 1, 32'h250, 0),
                  eo(1, 0, 1, 1, 32'h200, 32'h250, 32'h204)};
      tbl[3]  = '{mk(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1),
                  eo(0, 0, 0, 0, 32'h200, 32'h250, 32'h204)};
      tbl[4]  = '{mk(1, 1, 32'h300, 1, 32'h340, 1, 32'h380, 0),
                  eo(1, 1, 1, 1, 32'h300, 32'h340, 32'h340)};
      tbl[5]  = '{mk(1, 1, 32'h400, 1, 32'h500, 0, 32'h0, 0),
                  eo(0, 1, 0, 1, 32'h300, 32'h340, 32'h340)};
      tbl[6]  = '{mk(1, 1, 32'h404, 0, 32'h600, 1, 32'h600, 0),
                  eo(0, 1, 0, 1, 32'h300, 32'h340, 32'h340)};
      tbl[7]  = '{mk(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0),
                  eo(0, 1, 0, 1, 32'h300, 32'h340, 32'h340)};
      tbl[8]  = '{mk(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1),
                  eo(0, 1, 0, 0, 32'h300, 32'h340, 32'h340)};
      tbl[9]  = '{mk(1, 1, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10, 0),
                  eo(1, 0, 1, 1, 32'hFFFF_FFFC, 32'h10, 32'h0)};
      tbl[10] = '{mk(1, 1, 32'h800, 1, 32'h900, 0, 32'h0, 1),
                  eo(0, 0, 0, 0, 32'hFFFF_FFFC, 32'h10, 32'h0)};
      tbl[11] = '{mk(1, 1, 32'h500, 0, 32'h600, 0, 32'h0, 1),
                  eo(1, 0, 0, 0, 32'h500, 32'h600, 32'h0)};
      tbl[12] = '{mk(1, 1, 32'h504, 1, 32'h700, 1, 32'h700, 0),
                  eo(1, 1, 0, 0, 32'h504, 32'h700, 32'h0)};
      tbl[13] = '{mk(1, 0, 32'h508, 1, 32'h777, 0, 32'h0, 0),
                  eo(0, 1, 0, 0, 32'h504, 32'h700, 32'h0)};

      foreach (tbl[k]) begin
         drive(tbl[k].i);
         @(posedge clk);
         #1;
         check_outs($sformatf("vec%0d", k), tbl[k].o);
      end
      check_stats("table", 6, 3);

      // rdy low mid-redirect: pulses and redirect frozen, ack/branch ignored
      do_reset();
      drive(mk(1, 1, 32'h200, 0, 32'h250, 1, 32'h250, 0));
      @(posedge clk);
      #1;
      e = eo(1, 0, 1, 1, 32'h200, 32'h250, 32'h204);
      check_outs("rdy.pre", e);
      x = mk(1, 1, 32'h300, 1, 32'h340, 0, 32'h0, 1);
      x.rdy = 1'b0;
      drive(x);
      repeat (2) begin
         @(posedge clk);
         #1;
         check_outs("rdy.hold", e);
      end
      drive(mk(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0));
      @(posedge clk);
      #1;
      check_outs("rdy.resume", eo(0, 0, 0, 1, 32'h200, 32'h250, 32'h204));
      check_stats("rdy", 1, 1);

      // asynchronous reset mid-redirect, between clock edges
      #2 rst = 1'b1;
      #1;
      check_outs("async_rst", '0);
      check_stats("async_rst", 0, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // randomized run against the model
      do_reset();
      for (int n = 0; n < 3000 && errors < 20; n++) begin
         x.rdy        = ($urandom_range(0, 9) != 0);
         x.valid      = ($urandom_range(0, 9) < 7);
         x.is_branch  = ($urandom_range(0, 9) < 8);
         x.pc         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
         x.taken      = 1'($urandom_range(0, 1));
         x.target     = 32'h1000 + 32'($urandom_range(0, 3)) * 4;
         x.pred_taken = ($urandom_range(0, 3) != 0) ? x.taken : ~x.taken;
         x.pred_addr  = ($urandom_range(0, 2) != 0) ? x.target
                                                    : 32'h1000 + 32'($urandom_range(0, 3)) * 4;
         x.ack        = ($urandom_range(0, 9) < 4);
         drive(x);
         model_step(x);
         @(posedge clk);
         #1;
         check_outs($sformatf("rnd%0d", n), m_out);
         check_stats($sformatf("rnd%0d", n), m_nb, m_nm);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
